coin_accum_path: RTL and testbench

- Parametrised successor to the coffee-machine counter/comparator datapath.
- Accumulates multi-denomination coin credit into a saturating sum and compares it, registered, against a latched price.
- Raises a vend request to the controller with a req/ack handshake, then pays out change or a refund one unit per cycle.
- Sits between the coin-acceptor front end and the top-level control FSM.

---
 rtl/coin_accum_path_pkg.sv | 29 ++
 rtl/coin_accum_path_sat_comparator.sv | 34 +++
 rtl/coin_accum_path.sv | 173 +++++++++++++++++
 tb/tb_coin_accum_path.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_accum_path_pkg.sv
// Shared types for the coin credit datapath: FSM state encoding,
// the invalid-coin code and the denomination-to-credit lookup.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  localparam logic [1:0] COIN_INVALID = 2'd3;

  // Credit values live in the top-level parameters, so they are passed in.
  function automatic int unsigned coin_value(
    input logic [1:0]  sel,
    input int unsigned v0,
    input int unsigned v1,
    input int unsigned v2
  );
    case (sel)
      2'd0:    return v0;
      2'd1:    return v1;
      2'd2:    return v2;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_accum_path_sat_comparator.sv
// Registered unsigned a >= b compare. The result is forced low whenever
// en is low, so an empty transaction never reports enough credit.
module sat_comparator #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ge
);

  logic ge_q;
  logic ge_d;

  always_comb begin
    ge_d = 1'b0;
    if (en) begin
      ge_d = (a >= b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ge_q <= 1'b0;
    end else begin
      ge_q <= ge_d;
    end
  end

  assign ge = ge_q;

endmodule

// File: rtl/coin_accum_path.sv
// Coin credit accumulator: saturating sum, registered price compare,
// vend req/ack handshake and one-unit-per-cycle change/refund payout.
module coin_accum_path
  import coin_pkg::*;
#(
  parameter int unsigned SUM_W     = 6,
  parameter int unsigned COIN0_VAL = 1,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_clr,
  input  logic             coin_vld,
  input  logic [1:0]       coin_sel,
  input  logic [SUM_W-1:0] price,
  input  logic             chg_en,
  input  logic             vend_ack,
  output logic [SUM_W-1:0] Sum,
  output logic             Eql_grt,
  output logic             vend_req,
  output logic             coin_rej,
  output logic             ovf,
  output logic             chg_pulse,
  output logic             busy
);

  localparam logic [SUM_W-1:0] SUM_MAX  = '1;
  localparam logic [SUM_W-1:0] CHG_UNIT = SUM_W'(COIN0_VAL);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] price_q, price_d;
  logic [SUM_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             coin_rej_q, coin_rej_d;

  logic             coin_ok;
  logic [SUM_W-1:0] add_base;
  logic [SUM_W:0]   add_full;
  logic             add_clip;
  logic [SUM_W-1:0] add_sat;
  logic             cmp_en;
  logic             eql_grt;

  // One extra bit of headroom exposes the carry used to saturate.
  always_comb begin
    coin_ok  = coin_vld && (coin_sel != COIN_INVALID);
    add_base = (state_q == IDLE) ? '0 : sum_q;
    add_full = {1'b0, add_base}
             + (SUM_W+1)'(coin_value(coin_sel, COIN0_VAL, COIN1_VAL, COIN2_VAL));
    add_clip = add_full[SUM_W];
    add_sat  = add_clip ? SUM_MAX : add_full[SUM_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    price_d    = price_q;
    rem_d      = rem_q;
    ovf_d      = ovf_q;
    coin_rej_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          sum_d   = add_sat;
          price_d = price;
          ovf_d   = add_clip;
          state_d = ACCUM;
        end else if (coin_vld) begin
          coin_rej_d = 1'b1;
        end
      end

      ACCUM: begin
        if (cnt_clr) begin
          coin_rej_d = coin_vld;
          if (chg_en) begin
            rem_d   = sum_q / CHG_UNIT;
            state_d = CHANGE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (coin_ok) begin
            sum_d = add_sat;
            ovf_d = ovf_q | add_clip;
          end else if (coin_vld) begin
            coin_rej_d = 1'b1;
          end
          if (eql_grt) begin
            state_d = VEND;
          end
        end
      end

      VEND: begin
        coin_rej_d = coin_vld;
        if (vend_ack) begin
          if (chg_en && (sum_q > price_q)) begin
            rem_d   = (sum_q - price_q) / CHG_UNIT;
            state_d = CHANGE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      CHANGE: begin
        coin_rej_d = coin_vld;
        if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Any return to IDLE leaves the transaction registers empty.
    if (state_d == IDLE) begin
      sum_d   = '0;
      price_d = '0;
      rem_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      price_q    <= '0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      price_q    <= price_d;
      rem_q      <= rem_d;
      ovf_q      <= ovf_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  // Compare is held off on the way into or out of IDLE so it starts and ends cleared.
  assign cmp_en = (state_q != IDLE) && (state_d != IDLE);

  sat_comparator #(
    .W (SUM_W)
  ) u_cmp (
    .clk (clk),
    .rst (rst),
    .en  (cmp_en),
    .a   (sum_q),
    .b   (price_q),
    .ge  (eql_grt)
  );

  assign Sum       = sum_q;
  assign Eql_grt   = eql_grt;
  assign vend_req  = (state_q == VEND);
  assign coin_rej  = coin_rej_q;
  assign ovf       = ovf_q;
  assign chg_pulse = (state_q == CHANGE) && (rem_q != '0);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_coin_accum_path.sv
// Self-checking bench for coin_accum_path: hand sequences for latency,
// reject and reset corners, plus a table of whole transactions scored by a monitor.
module tb_coin_accum_path;

   logic       clk;
   logic       rst;
   logic       cnt_clr;
   logic       coin_vld;
   logic [1:0] coin_sel;
   logic [5:0] price;
   logic       chg_en;
   logic       vend_ack;
   logic [5:0] Sum;
   logic       Eql_grt;
   logic       vend_req;
   logic       coin_rej;
   logic       ovf;
   logic       chg_pulse;
   logic       busy;

   int total = 0;
   int bad   = 0;

   coin_accum_path #(
      .SUM_W     (6),
      .COIN0_VAL (1),
      .COIN1_VAL (5),
      .COIN2_VAL (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_clr   (cnt_clr),
      .coin_vld  (coin_vld),
      .coin_sel  (coin_sel),
      .price     (price),
      .chg_en    (chg_en),
      .vend_ack  (vend_ack),
      .Sum       (Sum),
      .Eql_grt   (Eql_grt),
      .vend_req  (vend_req),
      .coin_rej  (coin_rej),
      .ovf       (ovf),
      .chg_pulse (chg_pulse),
      .busy      (busy)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction description and the result the monitor should see for it
   typedef struct packed {
      logic [5:0]      price;
      logic            chg;
      logic            abort;
      logic [3:0]      n;
      logic [7:0][1:0] coins;
   } vec_t;

   typedef struct packed {
      logic       vend;
      logic [5:0] sum;
      logic       ovf;
      logic [6:0] pulses;
   } exp_t;

   exp_t sbq[$];
   vec_t vecs[7];

   // Every comparison funnels through here so the counters stay honest
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Drive one cycle of strobes, then drop them back to idle after the edge
   task automatic applyStimulus(input logic vld, input logic [1:0] sel, input logic clr, input logic ack);
      coin_vld = vld;
      coin_sel = sel;
      cnt_clr  = clr;
      vend_ack = ack;
      @(posedge clk);
      #1;
      coin_vld = 1'b0;
      cnt_clr  = 1'b0;
      vend_ack = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference model: saturating credit sum and the payout it implies
   function automatic exp_t computeExp(input vec_t v);
      exp_t e;
      int   s;
      int   val;
      bit   o;
      s = 0;
      o = 1'b0;
      for (int k = 0; k < int'(v.n); k++) begin
         case (v.coins[k])
            2'd0:    val = 1;
            2'd1:    val = 5;
            2'd2:    val = 10;
            default: val = 0;
         endcase
         s = s + val;
         if (s > 63) begin
            s = 63;
            o = 1'b1;
         end
      end
      e.vend = !v.abort;
      e.sum  = 6'(s);
      e.ovf  = o;
      if (v.abort)
         e.pulses = v.chg ? 7'(s / 1) : 7'd0;
      else
         e.pulses = (v.chg && (s > int'(v.price))) ? 7'((s - int'(v.price)) / 1) : 7'd0;
      return e;
   endfunction

   task automatic recoverReset();
      rst = 1'b1;
      idleCycles(2);
      rst = 1'b0;
      idleCycles(1);
   endtask

   task automatic waitVend(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (vend_req) ok = 1'b1;
         else idleCycles(1);
      end
      if (!ok) begin
         checkOutput("vend_req_timeout", 0, 1);
         recoverReset();
      end
   endtask

   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (!busy) done = 1'b1;
         else idleCycles(1);
      end
      if (!done) begin
         checkOutput("busy_timeout", 1, 0);
         recoverReset();
      end
   endtask

   task automatic runTxn(input vec_t v);
      bit ok;
      price  = v.price;
      chg_en = v.chg;
      sbq.push_back(computeExp(v));
      for (int k = 0; k < int'(v.n); k++) begin
         applyStimulus(1'b1, v.coins[k], 1'b0, 1'b0);
         idleCycles(1);
      end
      if (v.abort) begin
         applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
      end else begin
         waitVend(ok);
         if (ok) begin
            idleCycles(1);
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
         end
      end
      waitIdle();
      checkOutput("idle_sum", Sum, 0);
      checkOutput("idle_ovf", ovf, 0);
      checkOutput("idle_eql", Eql_grt, 0);
   endtask

   // Monitor: collects each transaction as busy runs, scores it when busy drops
   bit   busy_prev = 1'b0;
   bit   mon_vend;
   bit   mon_ovf;
   int   mon_pulses;
   int   mon_sum;
   exp_t e_pop;

   always @(negedge clk) begin
      if (rst) begin
         busy_prev = 1'b0;
      end else begin
         if (busy) begin
            if (!busy_prev) begin
               mon_vend   = 1'b0;
               mon_ovf    = 1'b0;
               mon_pulses = 0;
            end
            mon_sum = int'(Sum);
            if (chg_pulse) mon_pulses++;
            if (vend_req)  mon_vend = 1'b1;
            if (ovf)       mon_ovf  = 1'b1;
         end else if (busy_prev) begin
            if (sbq.size() == 0) begin
               checkOutput("sb_unexpected_txn", 1, 0);
            end else begin
               e_pop = sbq.pop_front();
               checkOutput("sb_vend",   mon_vend,   e_pop.vend);
               checkOutput("sb_sum",    mon_sum,    e_pop.sum);
               checkOutput("sb_ovf",    mon_ovf,    e_pop.ovf);
               checkOutput("sb_pulses", mon_pulses, e_pop.pulses);
            end
         end
         busy_prev = busy;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulses;
      bit ok;

      // Transaction table: last coin always the one that reaches the price
      vecs[0] = '{price: 6'd5,  chg: 1'b1, abort: 1'b0, n: 4'd1, coins: 16'h0001};
      vecs[1] = '{price: 6'd63, chg: 1'b1, abort: 1'b0, n: 4'd7, coins: 16'h2AAA};
      vecs[2] = '{price: 6'd20, chg: 1'b1, abort: 1'b1, n: 4'd2, coins: 16'h0001};
      vecs[3] = '{price: 6'd20, chg: 1'b0, abort: 1'b1, n: 4'd2, coins: 16'h0001};
      vecs[4] = '{price: 6'd7,  chg: 1'b0, abort: 1'b0, n: 4'd1, coins: 16'h0002};
      vecs[5] = '{price: 6'd8,  chg: 1'b1, abort: 1'b0, n: 4'd3, coins: 16'h0021};
      vecs[6] = '{price: 6'd30, chg: 1'b1, abort: 1'b0, n: 4'd4, coins: 16'h008A};

      rst      = 1'b1;
      cnt_clr  = 1'b0;
      coin_vld = 1'b0;
      coin_sel = 2'd0;
      price    = 6'd0;
      chg_en   = 1'b0;
      vend_ack = 1'b0;
      idleCycles(2);
      checkOutput("rst_sum",   Sum,       0);
      checkOutput("rst_eql",   Eql_grt,   0);
      checkOutput("rst_vend",  vend_req,  0);
      checkOutput("rst_rej",   coin_rej,  0);
      checkOutput("rst_ovf",   ovf,       0);
      checkOutput("rst_pulse", chg_pulse, 0);
      checkOutput("rst_busy",  busy,      0);
      rst = 1'b0;
      idleCycles(1);
      checkOutput("idle_eql_after_rst", Eql_grt, 0);

      $display("[TB] sequence: price 12, coins 10 then 5");
      price  = 6'd12;
      chg_en = 1'b1;
      sbq.push_back('{vend: 1'b1, sum: 6'd15, ovf: 1'b0, pulses: 7'd3});
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
      checkOutput("s1_sum10", Sum, 10);
      checkOutput("s1_busy", busy, 1);
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      checkOutput("s1_sum15", Sum, 15);
      checkOutput("s1_eql_n1", Eql_grt, 0);
      idleCycles(1);
      checkOutput("s1_eql_n2", Eql_grt, 1);
      checkOutput("s1_vend_early", vend_req, 0);
      idleCycles(1);
      checkOutput("s1_vend_up", vend_req, 1);
      idleCycles(1);
      checkOutput("s1_vend_held", vend_req, 1);
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      checkOutput("s1_vend_down", vend_req, 0);
      pulses = int'(chg_pulse);
      for (int i = 0; i < 4; i++) begin
         idleCycles(1);
         pulses += int'(chg_pulse);
      end
      checkOutput("s1_pulses", pulses, 3);
      checkOutput("s1_busy_end", busy, 0);
      checkOutput("s1_sum_end", Sum, 0);

      $display("[TB] sequence: invalid coin in IDLE");
      applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
      checkOutput("rej_idle_pulse", coin_rej, 1);
      checkOutput("rej_idle_busy", busy, 0);
      checkOutput("rej_idle_sum", Sum, 0);
      idleCycles(1);
      checkOutput("rej_idle_clear", coin_rej, 0);

      $display("[TB] sequence: coin during VEND");
      price  = 6'd5;
      chg_en = 1'b0;
      sbq.push_back('{vend: 1'b1, sum: 6'd5, ovf: 1'b0, pulses: 7'd0});
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      waitVend(ok);
      if (ok) begin
         applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
         checkOutput("rej_vend_pulse", coin_rej, 1);
         checkOutput("rej_vend_sum", Sum, 5);
         idleCycles(1);
         checkOutput("rej_vend_clear", coin_rej, 0);
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      end
      waitIdle();

      $display("[TB] table of transactions");
      for (int i = 0; i < 7; i++) begin
         runTxn(vecs[i]);
      end

      $display("[TB] sequence: reset mid-CHANGE");
      price  = 6'd6;
      chg_en = 1'b1;
      applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
      waitVend(ok);
      if (ok) begin
         applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
         checkOutput("rc_pulse_before", chg_pulse, 1);
         rst = 1'b1;
         #2;
         checkOutput("rc_pulse", chg_pulse, 0);
         checkOutput("rc_busy",  busy,      0);
         checkOutput("rc_sum",   Sum,       0);
         checkOutput("rc_eql",   Eql_grt,   0);
         @(posedge clk);
         #1;
         rst = 1'b0;
      end

      $display("[TB] sequence: reset mid-VEND");
      price  = 6'd5;
      chg_en = 1'b1;
      applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
      waitVend(ok);
      if (ok) begin
         rst = 1'b1;
         #2;
         checkOutput("rv_vend", vend_req, 0);
         checkOutput("rv_busy", busy,     0);
         checkOutput("rv_sum",  Sum,      0);
         checkOutput("rv_ovf",  ovf,      0);
         @(posedge clk);
         #1;
         rst = 1'b0;
      end

      $display("[TB] sequence: fresh transaction after reset");
      price  = 6'd1;
      chg_en = 1'b0;
      sbq.push_back('{vend: 1'b1, sum: 6'd1, ovf: 1'b0, pulses: 7'd0});
      applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
      checkOutput("fresh_sum", Sum, 1);
      waitVend(ok);
      if (ok) applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
      waitIdle();
      idleCycles(2);

      checkOutput("sb_left", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
